alu_exec_unit: RTL and testbench

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

---
 rtl/alu_exec_unit.sv | 151 +++++++++++++++
 tb/tb_alu_exec_unit.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// Single-issue ALU: one-cycle And/Or/Add/Sub, WIDTH-iteration shift-add multiply.
// Illegal control codes complete in one cycle with a zero result and illegal_o set.
module alu_exec_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             req_i,
  input  logic [2:0]       ctrl_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             ready_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             ovf_o,
  output logic             illegal_o
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b110;

  localparam int unsigned CNT_W = ($clog2(WIDTH + 1) > 5) ? $clog2(WIDTH + 1) : 5;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  state_t           state_q;
  state_t           state_d;

  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;

  logic             accept_c;
  logic             mul_done_c;
  logic [WIDTH-1:0] acc_nxt_c;
  logic [WIDTH-1:0] alu_res_c;
  logic             alu_ovf_c;
  logic             alu_illegal_c;
  logic [WIDTH-1:0] sum_c;
  logic [WIDTH-1:0] diff_c;

  // State register
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (req_i && (ctrl_i == OP_MUL)) state_d = S_MUL;
      S_MUL:  if (cnt_q == LAST_ITER) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM-decoded controls
  always_comb begin
    ready_o    = 1'b0;
    mul_done_c = 1'b0;
    case (state_q)
      S_IDLE: ready_o = 1'b1;
      S_MUL:  mul_done_c = (cnt_q == LAST_ITER);
      default: ready_o = 1'b0;
    endcase
  end

  assign accept_c = req_i && ready_o;

  // Single-cycle operations and signed overflow
  always_comb begin
    sum_c         = a_i + b_i;
    diff_c        = a_i - b_i;
    alu_res_c     = '0;
    alu_ovf_c     = 1'b0;
    alu_illegal_c = 1'b0;
    case (ctrl_i)
      OP_AND: alu_res_c = a_i & b_i;
      OP_OR:  alu_res_c = a_i | b_i;
      OP_ADD: begin
        alu_res_c = sum_c;
        alu_ovf_c = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum_c[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res_c = diff_c;
        alu_ovf_c = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (diff_c[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_MUL: alu_res_c = '0;
      default: alu_illegal_c = 1'b1;
    endcase
  end

  assign acc_nxt_c = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  // Datapath and result registers
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      valid_o   <= 1'b0;
      result_o  <= '0;
      zero_o    <= 1'b1;
      ovf_o     <= 1'b0;
      illegal_o <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      if (accept_c) begin
        if (ctrl_i == OP_MUL) begin
          mcand_q  <= a_i;
          mplier_q <= b_i;
          acc_q    <= '0;
          cnt_q    <= '0;
        end else begin
          valid_o   <= 1'b1;
          result_o  <= alu_res_c;
          zero_o    <= (alu_res_c == '0);
          ovf_o     <= alu_ovf_c;
          illegal_o <= alu_illegal_c;
        end
      end else if (state_q == S_MUL) begin
        acc_q    <= acc_nxt_c;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q + CNT_W'(1);
        if (mul_done_c) begin
          valid_o   <= 1'b1;
          result_o  <= acc_nxt_c;
          zero_o    <= (acc_nxt_c == '0);
          ovf_o     <= 1'b0;
          illegal_o <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit (WIDTH = 32).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_alu_exec_unit;

  logic        clk_i = 1'b0;
  logic        rst_n;
  logic        req_i;
  logic [2:0]  ctrl_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        ready_o;
  logic        valid_o;
  logic [31:0] result_o;
  logic        zero_o;
  logic        ovf_o;
  logic        illegal_o;

  // {valid, ready, result, zero, ovf, illegal}
  logic [36:0] obs;
  assign obs = {valid_o, ready_o, result_o, zero_o, ovf_o, illegal_o};

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk_i    (clk_i),
    .rst_n    (rst_n),
    .req_i    (req_i),
    .ctrl_i   (ctrl_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .ready_o  (ready_o),
    .valid_o  (valid_o),
    .result_o (result_o),
    .zero_o   (zero_o),
    .ovf_o    (ovf_o),
    .illegal_o(illegal_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic req, input logic [2:0] ctrl, input logic [31:0] a, input logic [31:0] b);
    req_i  = req;
    ctrl_i = ctrl;
    a_i    = a;
    b_i    = b;
  endtask

  task automatic test_reset();
    logic [36:0] exp;
    rst_n = 1'b0;
    drive(1'b0, 3'b000, 32'h0, 32'h0);
    #12;
    exp = {1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0};
    total_cnt++;
    if (obs !== exp) $display("FAIL reset_state: got %h want %h", obs, exp);
    else pass_cnt++;
    step();
    rst_n = 1'b1;
    step();
    total_cnt++;
    if (obs !== exp) $display("FAIL reset_idle: got %h want %h", obs, exp);
    else pass_cnt++;
  endtask

  task automatic test_add_sub();
    logic [36:0] exp;
    drive(1'b1, 3'b010, 32'h7FFF_FFFF, 32'h1);
    step();
    exp = {1'b1, 1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
    total_cnt++;
    if (obs !== exp) $display("FAIL add_ovf: got %h want %h", obs, exp);
    else pass_cnt++;
    drive(1'b1, 3'b010, 32'h8000_0000, 32'h8000_0000);
    step();
    exp = {1'b1, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0};
    total_cnt++;
    if (obs !== exp) $display("FAIL add_neg_ovf: got %h want %h", obs, exp);
    else pass_cnt++;
    drive(1'b1, 3'b010, 32'h0000_1234, 32'hFFFF_FFFF);
    step();
    exp = {1'b1, 1'b1, 32'h0000_1233, 1'b0, 1'b0, 1'b0};
    total_cnt++;
    if (obs !== exp) $display("FAIL add_plain: got %h want %h", obs, exp);
    else pass_cnt++;
    drive(1'b1, 3'b110, 32'h8000_0000, 32'h1);
    step();
    exp = {1'b1, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0};
    total_cnt++;
    if (obs !== exp) $display("FAIL sub_ovf: got %h want %h", obs, exp);
    else pass_cnt++;
    drive(1'b1, 3'b110, 32'h3, 32'h5);
    step();
    exp = {1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
    total_cnt++;
    if (obs !== exp) $display("FAIL sub_neg: got %h want %h", obs, exp);
    else pass_cnt++;
    drive(1'b0, 3'b000, 32'h0, 32'h0);
    step();
    exp = {1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
    total_cnt++;
    if (obs !== exp) $display("FAIL hold_after_sub: got %h want %h", obs, exp);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [36:0] exp;
    drive(1'b1, 3'b110, 32'h5, 32'h5);
    step();
    exp = {1'b1, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0};
    total_cnt++;
    if (obs !== exp) $display("FAIL b2b_sub: got %h want %h", obs, exp);
    else pass_cnt++;
    drive(1'b1, 3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00);
    step();
    exp = {1'b1, 1'b1, 32'hF000_F000, 1'b0, 1'b0, 1'b0};
    total_cnt++;
    if (obs !== exp) $display("FAIL b2b_and: got %h want %h", obs, exp);
    else pass_cnt++;
    drive(1'b1, 3'b001, 32'h0000_00F0, 32'h0F00_000F);
    step();
    exp = {1'b1, 1'b1, 32'h0F00_00FF, 1'b0, 1'b0, 1'b0};
    total_cnt++;
    if (obs !== exp) $display("FAIL b2b_or: got %h want %h", obs, exp);
    else pass_cnt++;
    drive(1'b0, 3'b001, 32'h1, 32'h1);
    step();
    exp = {1'b0, 1'b1, 32'h0F00_00FF, 1'b0, 1'b0, 1'b0};
    total_cnt++;
    if (obs !== exp) $display("FAIL b2b_idle: got %h want %h", obs, exp);
    else pass_cnt++;
  endtask

  task automatic test_illegal();
    logic [36:0] exp;
    logic [2:0]  codes [3];
    codes = '{3'b111, 3'b100, 3'b101};
    foreach (codes[i]) begin
      drive(1'b1, 3'b001, 32'hA5A5_0000, 32'h0000_5A5A);
      step();
      drive(1'b1, codes[i], 32'h1, 32'h1);
      step();
      exp = {1'b1, 1'b1, 32'h0, 1'b1, 1'b0, 1'b1};
      total_cnt++;
      if (obs !== exp) $display("FAIL illegal_%0d: got %h want %h", i, obs, exp);
      else pass_cnt++;
    end
    drive(1'b0, 3'b000, 32'h0, 32'h0);
    step();
  endtask

  task automatic test_mul();
    logic [36:0] exp;
    drive(1'b1, 3'b011, 32'hFFFF_FFFF, 32'h3);
    step();
    // Operands and request change during the multiply; both must be ignored.
    drive(1'b1, 3'b001, 32'h1234_5678, 32'h0);
    for (int k = 0; k < 32; k++) begin
      total_cnt++;
      if ({valid_o, ready_o} !== 2'b00)
        $display("FAIL mul_busy_%0d: got valid/ready %b want 00", k, {valid_o, ready_o});
      else pass_cnt++;
      step();
    end
    exp = {1'b1, 1'b1, 32'hFFFF_FFFD, 1'b0, 1'b0, 1'b0};
    total_cnt++;
    if (obs !== exp) $display("FAIL mul_result: got %h want %h", obs, exp);
    else pass_cnt++;
    drive(1'b0, 3'b000, 32'h0, 32'h0);
    step();
    exp = {1'b0, 1'b1, 32'hFFFF_FFFD, 1'b0, 1'b0, 1'b0};
    total_cnt++;
    if (obs !== exp) $display("FAIL mul_single_pulse: got %h want %h", obs, exp);
    else pass_cnt++;
  endtask

  task automatic test_mul_chain();
    logic [36:0] exp;
    drive(1'b1, 3'b011, 32'h7, 32'h9);
    step();
    drive(1'b0, 3'b000, 32'h0, 32'h0);
    for (int k = 0; k < 32; k++) step();
    exp = {1'b1, 1'b1, 32'h0000_003F, 1'b0, 1'b0, 1'b0};
    total_cnt++;
    if (obs !== exp) $display("FAIL mul_7x9: got %h want %h", obs, exp);
    else pass_cnt++;
    // New request accepted in the same cycle as the multiply's valid pulse.
    drive(1'b1, 3'b010, 32'h2, 32'h3);
    step();
    exp = {1'b1, 1'b1, 32'h5, 1'b0, 1'b0, 1'b0};
    total_cnt++;
    if (obs !== exp) $display("FAIL add_after_mul: got %h want %h", obs, exp);
    else pass_cnt++;
    drive(1'b1, 3'b011, 32'h0001_0000, 32'h0001_0000);
    step();
    drive(1'b0, 3'b000, 32'h0, 32'h0);
    for (int k = 0; k < 32; k++) step();
    exp = {1'b1, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0};
    total_cnt++;
    if (obs !== exp) $display("FAIL mul_wrap_zero: got %h want %h", obs, exp);
    else pass_cnt++;
    step();
  endtask

  task automatic test_reset_mid_mul();
    logic [36:0] exp;
    drive(1'b1, 3'b011, 32'h7, 32'h9);
    step();
    drive(1'b0, 3'b000, 32'h0, 32'h0);
    for (int k = 0; k < 10; k++) step();
    rst_n = 1'b0;
    #1;
    exp = {1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0};
    total_cnt++;
    if (obs !== exp) $display("FAIL midmul_reset: got %h want %h", obs, exp);
    else pass_cnt++;
    step();
    step();
    rst_n = 1'b1;
    drive(1'b1, 3'b001, 32'h1, 32'h2);
    total_cnt++;
    if (obs !== exp) $display("FAIL midmul_release: got %h want %h", obs, exp);
    else pass_cnt++;
    step();
    exp = {1'b1, 1'b1, 32'h3, 1'b0, 1'b0, 1'b0};
    total_cnt++;
    if (obs !== exp) $display("FAIL or_after_reset: got %h want %h", obs, exp);
    else pass_cnt++;
    drive(1'b0, 3'b000, 32'h0, 32'h0);
    for (int k = 0; k < 30; k++) begin
      step();
      total_cnt++;
      if (valid_o !== 1'b0) $display("FAIL no_late_mul_valid_%0d: got %b want 0", k, valid_o);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_back_to_back();
    test_illegal();
    test_mul();
    test_mul_chain();
    test_reset_mid_mul();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
